// File: rtl/scoreboard_pkg.sv
// Shared types and helpers for the round/match scoreboard.
// BCD digit arithmetic lives here so the counter and top agree on encoding.
package scoreboard_pkg;

   typedef enum logic [1:0] {ARM, ACTIVE, KO_HOLD, MATCH_OVER} state_t;

   typedef logic [3:0] bcd_t;

   localparam int unsigned MaxDigits = 8;

   // Returns {carry, digit}; 9 rolls to 0 with carry out.
   function automatic logic [4:0] bcd_digit_inc(input bcd_t d);
      if (d >= 4'd9) begin
         return {1'b1, 4'd0};
      end
      return {1'b0, d + 4'd1};
   endfunction

   function automatic logic [MaxDigits*4-1:0] int_to_bcd(input int unsigned v);
      logic [MaxDigits*4-1:0] res;
      int unsigned            rem;
      res = '0;
      rem = v;
      for (int i = 0; i < MaxDigits; i++) begin
         res[i*4 +: 4] = 4'(rem % 10);
         rem           = rem / 10;
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter that saturates at all nines.
// Clear wins over increment.
module bcd_counter
   import scoreboard_pkg::*;
#(
   parameter int unsigned DIGITS = 2
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  inc,
   input  logic                  clr,
   output logic [DIGITS*4-1:0]   value
);

   logic [DIGITS*4-1:0] value_q, value_d, value_inc;
   logic                all_nines;
   logic                carry;
   logic [4:0]          digit_res;

   always_comb begin
      all_nines = 1'b1;
      carry     = 1'b1;
      value_inc = value_q;
      digit_res = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (value_q[i*4 +: 4] != 4'd9) all_nines = 1'b0;
         if (carry) begin
            digit_res           = bcd_digit_inc(value_q[i*4 +: 4]);
            value_inc[i*4 +: 4] = digit_res[3:0];
            carry               = digit_res[4];
         end
      end
   end

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (inc && !all_nines) begin
         value_d = value_inc;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) value_q <= '0;
      else          value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/round_scoreboard.sv
// Round/match tracker: watches player health, decides round outcomes,
// keeps per-player BCD scores and sequences arm / fight / KO hold / match over.
module round_scoreboard
   import scoreboard_pkg::*;
#(
   parameter int unsigned N_PLAYERS   = 2,
   parameter int unsigned HEALTH_W    = 10,
   parameter int unsigned DIGITS      = 2,
   parameter int unsigned WIN_SCORE   = 5,
   parameter int unsigned HOLD_FRAMES = 120
) (
   input  logic                            Clk,
   input  logic                            Reset_n,
   input  logic                            frame_clk,
   input  logic                            clear_scores,
   input  logic [N_PLAYERS*HEALTH_W-1:0]   health,
   output logic [N_PLAYERS*DIGITS*4-1:0]   score_bcd,
   output logic [$clog2(N_PLAYERS)-1:0]    winner,
   output logic                            winner_valid,
   output logic                            round_active,
   output logic                            round_over,
   output logic                            match_over,
   output logic                            round_reset
);

   localparam int unsigned WinW   = $clog2(N_PLAYERS);
   localparam int unsigned AliveW = $clog2(N_PLAYERS + 1);
   localparam int unsigned HoldW  = $clog2(HOLD_FRAMES + 1);
   localparam int unsigned SW     = DIGITS * 4;
   localparam logic [SW-1:0] WinBcd = SW'(int_to_bcd(WIN_SCORE));

   state_t                         state_q, state_d;
   logic [HoldW-1:0]               hold_q, hold_d;
   logic [WinW-1:0]                winner_q, winner_d;
   logic                           wv_q, wv_d;
   logic                           rr_q, rr_d;
   logic                           clear_q;
   logic [2:0]                     frame_sync_q;
   logic                           frame_tick_q;
   logic [N_PLAYERS*HEALTH_W-1:0]  health_q;
   logic [AliveW-1:0]              alive;
   logic [WinW-1:0]                survivor;
   logic [N_PLAYERS-1:0]           inc;
   logic                           clr_scores;
   logic [SW-1:0]                  scores [N_PLAYERS];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_sync_q <= '0;
         frame_tick_q <= 1'b0;
         health_q     <= '0;
         clear_q      <= 1'b0;
         state_q      <= ARM;
         hold_q       <= '0;
         winner_q     <= '0;
         wv_q         <= 1'b0;
         rr_q         <= 1'b0;
      end else begin
         frame_sync_q <= {frame_sync_q[1:0], frame_clk};
         frame_tick_q <= frame_sync_q[1] & ~frame_sync_q[2];
         health_q     <= health;
         clear_q      <= clear_scores;
         state_q      <= state_d;
         hold_q       <= hold_d;
         winner_q     <= winner_d;
         wv_q         <= wv_d;
         rr_q         <= rr_d;
      end
   end

   // Only one player can be nonzero when alive == 1, so the last hit is the survivor.
   always_comb begin
      alive    = '0;
      survivor = '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
         if (health_q[i*HEALTH_W +: HEALTH_W] != '0) begin
            alive    = alive + AliveW'(1);
            survivor = WinW'(i);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      winner_d   = winner_q;
      wv_d       = wv_q;
      rr_d       = 1'b0;
      inc        = '0;
      clr_scores = 1'b0;
      if (clear_scores) begin
         state_d    = ARM;
         hold_d     = '0;
         winner_d   = '0;
         wv_d       = 1'b0;
         clr_scores = 1'b1;
         rr_d       = ~clear_q;
      end else begin
         unique case (state_q)
            ARM: begin
               hold_d = '0;
               if (alive == AliveW'(N_PLAYERS)) state_d = ACTIVE;
            end
            ACTIVE: begin
               if (alive <= AliveW'(1)) begin
                  state_d = KO_HOLD;
                  hold_d  = '0;
                  if (alive == AliveW'(1)) begin
                     inc[survivor] = 1'b1;
                     winner_d      = survivor;
                     wv_d          = 1'b1;
                  end else begin
                     wv_d = 1'b0;
                  end
               end
            end
            KO_HOLD: begin
               if (frame_tick_q) begin
                  if (hold_q == HoldW'(HOLD_FRAMES - 1)) begin
                     hold_d = '0;
                     if (wv_q && scores[winner_q] == WinBcd) begin
                        state_d = MATCH_OVER;
                     end else begin
                        state_d = ARM;
                        rr_d    = 1'b1;
                     end
                  end else begin
                     hold_d = hold_q + HoldW'(1);
                  end
               end
            end
            MATCH_OVER: ;
            default: state_d = ARM;
         endcase
      end
   end

   for (genvar g = 0; g < N_PLAYERS; g++) begin : g_player
      bcd_counter #(
         .DIGITS(DIGITS)
      ) u_score (
         .Clk    (Clk),
         .Reset_n(Reset_n),
         .inc    (inc[g]),
         .clr    (clr_scores),
         .value  (scores[g])
      );
      assign score_bcd[g*SW +: SW] = scores[g];
   end

   assign winner       = winner_q;
   assign winner_valid = wv_q;
   assign round_active = (state_q == ACTIVE);
   assign round_over   = (state_q == KO_HOLD);
   assign match_over   = (state_q == MATCH_OVER);
   assign round_reset  = rr_q;

endmodule
